dmem_arbiter_aes128: RTL and testbench

Two-requester arbiter that shares the single 128-bit data memory port between the RV32IMV CPU and a block-transfer (DMA) engine. The DMA engine preloads plaintext and round keys and drains ciphertext. The block sits between both requesters and the data memory. It holds a registered ownership state and applies alternating priority, a hold limit and a lock qualifier. It gates the memory write strobes so that only the current owner can write.

---
 rtl/dmem_arbiter_aes128_pkg.sv | 13 +
 rtl/dmem_arbiter_aes128_if.sv | 34 +++
 rtl/dmem_arbiter_aes128_port_mux.sv | 49 ++++
 rtl/dmem_arbiter_aes128.sv | 102 ++++++++++
 tb/tb_dmem_arbiter_aes128.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_aes128_pkg.sv
// Shared definitions for the data-memory arbiter: ownership encoding and default bus widths.
package dmem_arbiter_aes128_pkg;

   localparam int unsigned DefVlen = 128;
   localparam int unsigned DefAw   = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwnC = 2'd1,
      StOwnD = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_aes128_if.sv
// CPU, DMA and memory-side signals of the shared data-memory port.
interface dmem_arbiter_aes128_if
   import dmem_arbiter_aes128_pkg::*;
#(
   parameter int unsigned VLEN = DefVlen,
   parameter int unsigned AW   = DefAw
);
   logic            c_req,    d_req;
   logic            c_lock,   d_lock;
   logic [AW-1:0]   c_addr,   d_addr;
   logic [VLEN-1:0] c_wdata,  d_wdata;
   logic [3:0]      c_wmem,   d_wmem;
   logic            c_vector, d_vector;
   logic            c_gnt,    d_gnt;
   logic [VLEN-1:0] c_rdata,  d_rdata;
   logic [AW-1:0]   m_addr;
   logic [VLEN-1:0] m_wdata;
   logic [3:0]      m_wmem;
   logic            m_vector;
   logic [VLEN-1:0] m_rdata;

   modport slave (
      input  c_req, d_req, c_lock, d_lock, c_addr, d_addr, c_wdata, d_wdata,
             c_wmem, d_wmem, c_vector, d_vector, m_rdata,
      output c_gnt, d_gnt, c_rdata, d_rdata, m_addr, m_wdata, m_wmem, m_vector
   );

   modport master (
      output c_req, d_req, c_lock, d_lock, c_addr, d_addr, c_wdata, d_wdata,
             c_wmem, d_wmem, c_vector, d_vector, m_rdata,
      input  c_gnt, d_gnt, c_rdata, d_rdata, m_addr, m_wdata, m_wmem, m_vector
   );

endinterface

// File: rtl/dmem_arbiter_aes128_port_mux.sv
// Owner-select mux toward memory; write strobes only pass for a requesting owner outside reset.
module dmem_port_mux
   import dmem_arbiter_aes128_pkg::*;
#(
   parameter int unsigned VLEN = DefVlen,
   parameter int unsigned AW   = DefAw
) (
   input  arb_state_e      state_i,
   input  logic            clr_i,
   input  logic            c_req_i,
   input  logic [AW-1:0]   c_addr_i,
   input  logic [VLEN-1:0] c_wdata_i,
   input  logic [3:0]      c_wmem_i,
   input  logic            c_vector_i,
   input  logic            d_req_i,
   input  logic [AW-1:0]   d_addr_i,
   input  logic [VLEN-1:0] d_wdata_i,
   input  logic [3:0]      d_wmem_i,
   input  logic            d_vector_i,
   output logic [AW-1:0]   m_addr_o,
   output logic [VLEN-1:0] m_wdata_o,
   output logic [3:0]      m_wmem_o,
   output logic            m_vector_o
);

   always_comb begin
      m_addr_o   = '0;
      m_wdata_o  = '0;
      m_wmem_o   = '0;
      m_vector_o = 1'b0;
      unique case (state_i)
         StOwnC: begin
            m_addr_o   = c_addr_i;
            m_wdata_o  = c_wdata_i;
            m_wmem_o   = c_wmem_i & {4{c_req_i}};
            m_vector_o = c_vector_i;
         end
         StOwnD: begin
            m_addr_o   = d_addr_i;
            m_wdata_o  = d_wdata_i;
            m_wmem_o   = d_wmem_i & {4{d_req_i}};
            m_vector_o = d_vector_i;
         end
         default: ;
      endcase
      if (clr_i) m_wmem_o = '0;
   end

endmodule

// File: rtl/dmem_arbiter_aes128.sv
// CPU/DMA arbiter for the 128-bit data memory: alternating tie priority, hold limit, owner lock.
module dmem_arbiter_aes128
   import dmem_arbiter_aes128_pkg::*;
#(
   parameter int unsigned VLEN     = DefVlen,
   parameter int unsigned AW       = DefAw,
   parameter int unsigned MAX_HOLD = 8
) (
   input logic                  clk,
   input logic                  clr,
   dmem_arbiter_aes128_if.slave bus
);

   localparam logic [7:0] HoldMax = 8'(MAX_HOLD);
   localparam logic [7:0] HoldRel = 8'(MAX_HOLD - 1);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] hold_q, hold_d;
   logic       c_rel, d_rel;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   // Compare with >= so a saturated counter (after a lock or an uncontested stretch)
   // still yields to a waiting competitor instead of starving it.
   assign c_rel = !bus.c_lock && (!bus.c_req || (hold_q >= HoldRel && bus.d_req));
   assign d_rel = !bus.d_lock && (!bus.d_req || (hold_q >= HoldRel && bus.c_req));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.c_req && bus.d_req) state_d = last_q ? StOwnC : StOwnD;
            else if (bus.c_req)         state_d = StOwnC;
            else if (bus.d_req)         state_d = StOwnD;
         end
         StOwnC: begin
            if (c_rel) begin
               if (bus.d_req)       state_d = StOwnD;
               else if (!bus.c_req) state_d = StIdle;
            end
         end
         StOwnD: begin
            if (d_rel) begin
               if (bus.c_req)       state_d = StOwnC;
               else if (!bus.d_req) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (state_d == StOwnC)      last_d = 1'b0;
      else if (state_d == StOwnD) last_d = 1'b1;

      hold_d = hold_q;
      if (state_d != state_q)                       hold_d = '0;
      else if (state_q != StIdle && hold_q != HoldMax) hold_d = hold_q + 8'd1;
   end

   always_comb begin
      bus.c_gnt   = (state_q == StOwnC);
      bus.d_gnt   = (state_q == StOwnD);
      bus.c_rdata = bus.c_gnt ? bus.m_rdata : '0;
      bus.d_rdata = bus.d_gnt ? bus.m_rdata : '0;
   end

   dmem_port_mux #(
      .VLEN (VLEN),
      .AW   (AW)
   ) u_port_mux (
      .state_i    (state_q),
      .clr_i      (clr),
      .c_req_i    (bus.c_req),
      .c_addr_i   (bus.c_addr),
      .c_wdata_i  (bus.c_wdata),
      .c_wmem_i   (bus.c_wmem),
      .c_vector_i (bus.c_vector),
      .d_req_i    (bus.d_req),
      .d_addr_i   (bus.d_addr),
      .d_wdata_i  (bus.d_wdata),
      .d_wmem_i   (bus.d_wmem),
      .d_vector_i (bus.d_vector),
      .m_addr_o   (bus.m_addr),
      .m_wdata_o  (bus.m_wdata),
      .m_wmem_o   (bus.m_wmem),
      .m_vector_o (bus.m_vector)
   );

endmodule

// File: tb/tb_dmem_arbiter_aes128.sv
// Bench for dmem_arbiter_aes128: owner model plus memory model, checked every cycle.
module tb_dmem_arbiter_aes128;

   localparam int MaxHold = 8;

   logic clk = 1'b0;
   logic clr;
   logic mem_init;
   logic chk_en = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [127:0] mem     [64];
   logic [127:0] ref_mem [64];

   dmem_arbiter_aes128_if #(.VLEN(128), .AW(32)) bus ();

   dmem_arbiter_aes128 #(
      .VLEN     (128),
      .AW       (32),
      .MAX_HOLD (MaxHold)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory driven by the DUT's memory-side outputs.
   assign bus.m_rdata = mem[bus.m_addr[9:4]];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else begin
         for (int l = 0; l < 4; l++)
            if (bus.m_wmem[l]) mem[bus.m_addr[9:4]][l*32 +: 32] <= bus.m_wdata[l*32 +: 32];
      end
   end

   // Model: owner 0 = nobody, 1 = CPU, 2 = DMA; run = cycles already owned this tenure.
   int m_own  = 0;
   bit m_last = 1'b1;
   int m_run  = 0;

   function automatic int f_next(int own, bit last_dma, int run, bit cr, bit dr, bit cl, bit dl);
      bit mine_r, mine_l, oth_r;
      if (own == 0) begin
         if (cr && dr) return last_dma ? 1 : 2;
         if (cr) return 1;
         if (dr) return 2;
         return 0;
      end
      mine_r = (own == 1) ? cr : dr;
      mine_l = (own == 1) ? cl : dl;
      oth_r  = (own == 1) ? dr : cr;
      if (mine_l) return own;
      if (mine_r && !(oth_r && run + 1 >= MaxHold)) return own;
      if (oth_r) return 3 - own;
      if (mine_r) return own;
      return 0;
   endfunction

   function automatic logic [3:0] f_exp_wmem();
      if (clr) return 4'h0;
      if (m_own == 1) return bus.c_req ? bus.c_wmem : 4'h0;
      if (m_own == 2) return bus.d_req ? bus.d_wmem : 4'h0;
      return 4'h0;
   endfunction

   function automatic logic [31:0] f_exp_addr();
      if (m_own == 1) return bus.c_addr;
      if (m_own == 2) return bus.d_addr;
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) ref_mem[i] <= '0;
      end else if (!clr) begin
         for (int l = 0; l < 4; l++)
            if (f_exp_wmem() [l])
               ref_mem[f_exp_addr() [9:4]][l*32 +: 32] <=
                  ((m_own == 1) ? bus.c_wdata[l*32 +: 32] : bus.d_wdata[l*32 +: 32]);
      end
      if (clr) begin
         m_own  <= 0;
         m_last <= 1'b1;
         m_run  <= 0;
      end else begin
         m_own <= f_next(m_own, m_last, m_run, bus.c_req, bus.d_req, bus.c_lock, bus.d_lock);
         if (f_next(m_own, m_last, m_run, bus.c_req, bus.d_req, bus.c_lock, bus.d_lock) == 1)
            m_last <= 1'b0;
         else if (f_next(m_own, m_last, m_run, bus.c_req, bus.d_req, bus.c_lock, bus.d_lock) == 2)
            m_last <= 1'b1;
         if (m_own != 0 &&
             f_next(m_own, m_last, m_run, bus.c_req, bus.d_req, bus.c_lock, bus.d_lock) == m_own)
            m_run <= (m_run < 1000) ? m_run + 1 : m_run;
         else
            m_run <= 0;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0]  ea;
         logic [127:0] rd;
         ea = f_exp_addr();
         rd = ref_mem[ea[9:4]];
         chk("c_gnt", bus.c_gnt, m_own == 1);
         chk("d_gnt", bus.d_gnt, m_own == 2);
         chk("m_addr", bus.m_addr, ea);
         chk("m_wmem", bus.m_wmem, f_exp_wmem());
         chk("m_wdata", bus.m_wdata,
             (m_own == 1) ? bus.c_wdata : (m_own == 2) ? bus.d_wdata : 128'h0);
         chk("m_vector", bus.m_vector,
             (m_own == 1) ? bus.c_vector : (m_own == 2) ? bus.d_vector : 1'b0);
         chk("c_rdata", bus.c_rdata, (m_own == 1) ? rd : 128'h0);
         chk("d_rdata", bus.d_rdata, (m_own == 2) ? rd : 128'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b1;
      mem_init = 1'b1;
      bus.c_req = 1'b1;  bus.d_req = 1'b1;
      bus.c_lock = 1'b0; bus.d_lock = 1'b0;
      bus.c_addr = '0;   bus.d_addr = '0;
      bus.c_wdata = '0;  bus.d_wdata = '0;
      bus.c_wmem = 4'hF; bus.d_wmem = 4'h0;
      bus.c_vector = 1'b0; bus.d_vector = 1'b0;

      // Reset held two cycles with both requesting and a CPU write pending.
      step();
      mem_init = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_m_wmem", bus.m_wmem, 4'h0);
      chk("rst_c_gnt", bus.c_gnt, 1'b0);
      step();
      clr = 1'b0;
      bus.c_wmem = 4'h0;
      @(negedge clk);
      chk("rst_idle_gnt", {bus.c_gnt, bus.d_gnt}, 2'b00);
      step();

      // Tie alternation: CPU x8, DMA x8, CPU x8.
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         chk("tie_c", bus.c_gnt, (i < 8 || i >= 16));
         chk("tie_d", bus.d_gnt, (i >= 8 && i < 16));
         step();
      end
      bus.c_req = 1'b0;
      bus.d_req = 1'b0;
      step();
      step();

      // Lock: DMA keeps the port for 20 cycles with a waiting CPU.
      bus.d_req = 1'b1;
      step();
      bus.d_lock = 1'b1;
      bus.c_req = 1'b1;
      bus.d_wmem = 4'hF;
      bus.d_addr = 32'h80;
      bus.d_wdata = {16{8'h3C}};
      for (int i = 0; i < 20; i++) begin
         bus.d_req = (i % 2 == 0);
         @(negedge clk);
         chk("lock_d_gnt", bus.d_gnt, 1'b1);
         chk("lock_wmem", bus.m_wmem, (i % 2 == 0) ? 4'hF : 4'h0);
         step();
      end
      bus.d_lock = 1'b0;
      bus.d_req = 1'b1;
      @(negedge clk);
      chk("unlock_d_gnt", bus.d_gnt, 1'b1);
      step();
      @(negedge clk);
      chk("unlock_c_gnt", bus.c_gnt, 1'b1);
      chk("lock_mem_80", mem[8], {16{8'h3C}});
      step();

      // Write isolation: CPU writes 0x40, DMA presents a competing write but is not owner.
      bus.d_req = 1'b0;
      bus.c_wmem = 4'hF;
      bus.c_addr = 32'h40;
      bus.c_wdata = {16{8'hAA}};
      bus.c_vector = 1'b1;
      bus.d_wmem = 4'hF;
      bus.d_addr = 32'h40;
      bus.d_wdata = {16{8'h55}};
      @(negedge clk);
      chk("wr_m_wmem", bus.m_wmem, 4'hF);
      chk("wr_d_rdata", bus.d_rdata, 128'h0);
      step();
      chk("wr_mem_40", mem[4], {16{8'hAA}});

      // Read path: same-cycle data.
      bus.c_wmem = 4'h0;
      @(negedge clk);
      chk("rd_c_rdata", bus.c_rdata, {16{8'hAA}});
      chk("rd_d_rdata", bus.d_rdata, 128'h0);
      step();

      // Reset in the middle of a DMA write.
      bus.c_req = 1'b0;
      bus.c_vector = 1'b0;
      bus.d_req = 1'b1;
      bus.d_wmem = 4'h0;
      step();
      bus.d_wmem = 4'h1;
      bus.d_addr = 32'hC0;
      bus.d_wdata = {16{8'h77}};
      clr = 1'b1;
      @(negedge clk);
      chk("clr_d_gnt", bus.d_gnt, 1'b1);
      chk("clr_wmem", bus.m_wmem, 4'h0);
      step();
      clr = 1'b0;
      bus.c_req = 1'b1;
      bus.d_wmem = 4'h0;
      @(negedge clk);
      chk("clr_idle", {bus.c_gnt, bus.d_gnt}, 2'b00);
      chk("clr_mem_c0", mem[12], 128'h0);
      step();
      @(negedge clk);
      chk("clr_tie_c", bus.c_gnt, 1'b1);
      step();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
